division_request_scheduler: RTL
===============================

# division_request_scheduler

Front-end and back-end stage wrapped around the 5-bit / 4-bit restoring slow divider. It accepts division requests on a valid/ready port and buffers them in a small FIFO. It presents one request at a time to the divider, discards stale `done` pulses and captures the quotient/remainder. Results go out on a valid/ready port with a divide-by-zero flag.

## Interface
- `FIFO_DEPTH`, default 4: request FIFO entries; power of two, ≥2.
- `DONE_SKIP`, default 1: rising edges of `div_done` discarded after new operands are driven, since the divider may be finishing a stale computation.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `in_valid` input 1: request present.
- `in_ready` output 1: FIFO can accept; equals !full.
- `in_n` input 5: dividend.
- `in_d` input 4: divisor.
- `div_n` output 5: dividend to divider; registered, stable until capture.
- `div_d` output 4: divisor to divider; registered, stable until capture.
- `div_done` input 1: divider done; edge-detected internally.
- `div_q` input 5: divider quotient.
- `div_r` input 4: divider remainder.
- `out_valid` output 1: result held.
- `out_ready` input 1: consumer accepts.
- `out_q` output 5: quotient.
- `out_r` output 4: remainder.
- `out_dz` output 1: divisor was zero.

## Operation
- FIFO push when `in_valid && in_ready`; pop only in IDLE. Push to a full FIFO is impossible because `in_ready` is low. Push and pop in the same cycle are allowed at any occupancy below full; occupancy is unchanged. Read/write pointers wrap modulo `FIFO_DEPTH`, with an extra wrap bit for full/empty.
- `done_rise` = `div_done && !done_q`; `done_q` is a register of `div_done`.
- States:
  - IDLE
    - FIFO non-empty: pop; load `div_n`/`div_d` from the head entry.
    - Head divisor == 0: go to HOLD with `out_q`=5'd31, `out_r`=4'd0, `out_dz`=1. `div_n`/`div_d` still load.
    - Otherwise: go to SKIP, with skip counter = `DONE_SKIP`. If `DONE_SKIP`=0, go to CAPTURE.
  - SKIP: each `done_rise` decrements the counter. At `done_rise` with counter==1, go to CAPTURE.
  - CAPTURE: on `done_rise`, register `div_q`→`out_q` and `div_r`→`out_r`, set `out_dz`=0, and go to HOLD.
  - HOLD: `out_valid`=1; outputs frozen. When `out_ready`=1, go to IDLE.
- `done_rise` in IDLE or HOLD is ignored.
- Results leave in request order; no reordering or dropping.
- Reset (asynchronous, any state): FIFO empty, state IDLE, `done_q`=0, counter 0.
- Output reset values: `in_ready`=1, `div_n`=0, `div_d`=0, `out_valid`=0, `out_q`=0, `out_r`=0, `out_dz`=0.

## Timing
- `in_ready` is combinational from FIFO occupancy only, so a full FIFO releases `in_ready` the cycle after a pop.
- IDLE → next state on the pop edge; `div_n`/`div_d` are valid from that edge on.
- Zero divisor: `out_valid` is high in the first cycle after the pop edge (latency 1 from pop).
- Nonzero divisor: `out_valid` rises one cycle after the clock edge sampling the (`DONE_SKIP`+1)th `done_rise` following the pop.
- HOLD → IDLE on the edge where `out_ready`=1. `out_valid` drops in the next cycle. The earliest next pop is that IDLE cycle, so throughput is at most one request per 2 cycles.
- `out_valid` never deasserts without acceptance; `out_q`/`out_r`/`out_dz` are stable while `out_valid`=1.

## Test plan
- 5 / 2, `out_ready`=1, divider model pulsing done → `out_q`=2, `out_r`=1, `out_dz`=0. Exactly `DONE_SKIP`+1 done pulses elapse before `out_valid`.
- Back-to-back 5/2 then 10/6 → results in order: (2,1), then (1,4). `div_n`/`div_d` change only after the first result is accepted.
- 7 / 0 → `out_valid` one cycle after pop with `out_q`=31, `out_r`=0, `out_dz`=1. `div_done` activity is ignored.
- `out_ready`=0, push 6 requests at `FIFO_DEPTH`=4 → one request in flight, `in_ready` low after 5 accepted. Raise `out_ready` → all 5 results emerge in order; the sixth is accepted after the first pop.
- Simultaneous push and pop at occupancy 2 → occupancy stays 2; no request lost or duplicated.
- `reset` low while in SKIP with 3 entries queued → immediately `out_valid`=0 and `in_ready`=1. After release, a new 9/4 request returns (2,1) with no stale results.

Source files
------------

// File: rtl/division_request_scheduler.sv
// Request FIFO, operand staging and result capture around a 5-bit / 4-bit slow divider.
// Stale done pulses are skipped after each operand load so only the fresh result is captured.
module division_request_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int DONE_SKIP  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_n,
    input  logic [3:0] in_d,
    output logic [4:0] div_n,
    output logic [3:0] div_d,
    input  logic       div_done,
    input  logic [4:0] div_q,
    input  logic [3:0] div_r,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_q,
    output logic [3:0] out_r,
    output logic       out_dz
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (DONE_SKIP > 1) ? $clog2(DONE_SKIP + 1) : 1;
    localparam logic [CW-1:0] SKIP_INIT = CW'(DONE_SKIP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_CAPTURE,
        ST_HOLD
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          done_q_reg;
    logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
    logic [4:0]    div_n_reg, div_n_next;
    logic [3:0]    div_d_reg, div_d_next;
    logic [4:0]    out_q_reg, out_q_next;
    logic [3:0]    out_r_reg, out_r_next;
    logic          out_dz_reg, out_dz_next;

    logic [8:0]    fifo_mem [FIFO_DEPTH];
    logic [8:0]    head;
    logic          fifo_empty, fifo_full, push, pop, done_rise;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && !fifo_full;
    assign pop        = (state_reg == ST_IDLE) && !fifo_empty;
    assign head       = fifo_mem[rd_ptr_reg[AW-1:0]];
    assign done_rise  = div_done && !done_q_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= {in_n, in_d};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            done_q_reg <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            div_n_reg  <= '0;
            div_d_reg  <= '0;
            out_q_reg  <= '0;
            out_r_reg  <= '0;
            out_dz_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            done_q_reg <= div_done;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            div_n_reg  <= div_n_next;
            div_d_reg  <= div_d_next;
            out_q_reg  <= out_q_next;
            out_r_reg  <= out_r_next;
            out_dz_reg <= out_dz_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        div_n_next  = div_n_reg;
        div_d_next  = div_d_reg;
        out_q_next  = out_q_reg;
        out_r_next  = out_r_reg;
        out_dz_next = out_dz_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    div_n_next = head[8:4];
                    div_d_next = head[3:0];
                    if (head[3:0] == 4'd0) begin
                        // Divide by zero never reaches the divider result path.
                        out_q_next  = 5'd31;
                        out_r_next  = 4'd0;
                        out_dz_next = 1'b1;
                        state_next  = ST_HOLD;
                    end else if (DONE_SKIP == 0) begin
                        state_next = ST_CAPTURE;
                    end else begin
                        cnt_next   = SKIP_INIT;
                        state_next = ST_SKIP;
                    end
                end
            end
            ST_SKIP: begin
                if (done_rise) begin
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (done_rise) begin
                    out_q_next  = div_q;
                    out_r_next  = div_r;
                    out_dz_next = 1'b0;
                    state_next  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign div_n     = div_n_reg;
    assign div_d     = div_d_reg;
    assign out_q     = out_q_reg;
    assign out_r     = out_r_reg;
    assign out_dz    = out_dz_reg;
    assign out_valid = (state_reg == ST_HOLD);

endmodule
